// File: rtl/cpu_exec_controller.sv
// Execution sequencer for the monocycle CPU: issues single-cycle clock enables
// for single-step, divided free-run, and stops on a PC breakpoint.
module cpu_exec_controller #(
   parameter int unsigned CLK_FREQ_HZ = 50000000,
   parameter int unsigned RUN_RATE_HZ = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        step_pulse,
   input  logic        run_pulse,
   input  logic        halt_pulse,
   input  logic        bp_enable,
   input  logic [31:0] bp_addr,
   input  logic [31:0] debug_pc,
   output logic        cpu_step_en,
   output logic [1:0]  exec_state,
   output logic [31:0] step_count,
   output logic        bp_hit
);

   localparam int unsigned DIV = CLK_FREQ_HZ / RUN_RATE_HZ;
   localparam int unsigned DW  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   if (DIV < 2) begin : g_div_check
      $error("cpu_exec_controller: CLK_FREQ_HZ/RUN_RATE_HZ must be at least 2");
   end

   typedef enum logic [1:0] {
      ST_HALTED = 2'b00,
      ST_RUN    = 2'b01,
      ST_BREAK  = 2'b10
   } state_e;

   state_e         state_q, state_d;
   logic [DW-1:0]  div_q, div_d;
   logic           step_en_q, step_en_d;
   logic [31:0]    count_q, count_d;
   logic           bp_hit_q, bp_hit_d;
   logic           pending_q, pending_d;
   logic           bp_match;

   assign bp_match = bp_enable && (debug_pc == bp_addr);

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      step_en_d = 1'b0;
      count_d   = count_q;
      bp_hit_d  = bp_hit_q;
      // The PC settles one cycle after an enable; that is the only cycle it is compared.
      pending_d = step_en_q;

      case (state_q)
         ST_HALTED: begin
            if (halt_pulse) begin
               state_d = ST_HALTED;
            end else if (run_pulse) begin
               state_d   = ST_RUN;
               div_d     = '0;
               pending_d = 1'b0;
            end else if (step_pulse && !step_en_q) begin
               step_en_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (halt_pulse || run_pulse) begin
               state_d = ST_HALTED;
               div_d   = '0;
            end else if (pending_q && bp_match) begin
               state_d  = ST_BREAK;
               bp_hit_d = 1'b1;
            end else if (div_q == DIV_LAST) begin
               div_d     = '0;
               step_en_d = 1'b1;
            end else begin
               div_d = div_q + DW'(1);
            end
         end
         ST_BREAK: begin
            if (halt_pulse) begin
               state_d  = ST_HALTED;
               bp_hit_d = 1'b0;
            end else if (run_pulse) begin
               state_d   = ST_RUN;
               div_d     = '0;
               bp_hit_d  = 1'b0;
               pending_d = 1'b0;
            end else if (step_pulse && !step_en_q) begin
               step_en_d = 1'b1;
            end
         end
         default: begin
            state_d  = ST_HALTED;
            div_d    = '0;
            bp_hit_d = 1'b0;
         end
      endcase

      if (step_en_d) begin
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_HALTED;
         div_q     <= '0;
         step_en_q <= 1'b0;
         count_q   <= '0;
         bp_hit_q  <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         step_en_q <= step_en_d;
         count_q   <= count_d;
         bp_hit_q  <= bp_hit_d;
         pending_q <= pending_d;
      end
   end

   assign cpu_step_en = step_en_q;
   assign exec_state  = state_q;
   assign step_count  = count_q;
   assign bp_hit      = bp_hit_q;

endmodule

// File: tb/tb_cpu_exec_controller.sv
// Self-checking bench for cpu_exec_controller: vector table, directed
// multi-cycle sequences and a randomized run against a timestamp-based model.
module tb_cpu_exec_controller;

   localparam int unsigned DIV = 10;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        step_pulse, run_pulse, halt_pulse;
   logic        bp_enable;
   logic [31:0] bp_addr, debug_pc;
   logic        cpu_step_en;
   logic [1:0]  exec_state;
   logic [31:0] step_count;
   logic        bp_hit;

   cpu_exec_controller #(
      .CLK_FREQ_HZ(100),
      .RUN_RATE_HZ(10)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .step_pulse (step_pulse),
      .run_pulse  (run_pulse),
      .halt_pulse (halt_pulse),
      .bp_enable  (bp_enable),
      .bp_addr    (bp_addr),
      .debug_pc   (debug_pc),
      .cpu_step_en(cpu_step_en),
      .exec_state (exec_state),
      .step_count (step_count),
      .bp_hit     (bp_hit)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: mode plus absolute edge timestamps of the next run tick
   // and of the pending breakpoint compare.
   int          m_state;   // 0 halted, 1 run, 2 break
   longint      m_edge = 0;
   longint      m_next_tick;
   longint      m_check;
   bit          m_en;
   logic [31:0] m_count;
   logic [31:0] m_pc;

   function automatic void model_reset();
      m_state     = 0;
      m_next_tick = -1;
      m_check     = -1;
      m_en        = 1'b0;
      m_count     = '0;
      m_pc        = '0;
   endfunction

   function automatic void model_edge(bit s, bit r, bit h);
      bit en    = 1'b0;
      bit prev  = m_en;
      bit match = bp_enable && (bp_addr == m_pc);
      case (m_state)
         0: begin
            if (h) begin
            end else if (r) begin
               m_state = 1; m_next_tick = m_edge + DIV; m_check = -1;
            end else if (s && !prev) en = 1'b1;
         end
         1: begin
            if (h || r) begin
               m_state = 0;
            end else if (m_check == m_edge && match) begin
               m_state = 2;
            end else if (m_edge == m_next_tick) begin
               en = 1'b1; m_next_tick = m_edge + DIV; m_check = m_edge + 2;
            end
         end
         default: begin
            if (h) m_state = 0;
            else if (r) begin
               m_state = 1; m_next_tick = m_edge + DIV; m_check = -1;
            end else if (s && !prev) en = 1'b1;
         end
      endcase
      if (prev) m_pc = m_pc + 32'd4;
      m_en = en;
      if (en) m_count = m_count + 32'd1;
      m_edge++;
   endfunction

   task automatic tick(input bit s, input bit r, input bit h);
      step_pulse = s; run_pulse = r; halt_pulse = h;
      debug_pc   = m_pc;
      @(posedge clk);
      model_edge(s, r, h);
      #1;
      chk("m_en",    32'(cpu_step_en), 32'(m_en));
      chk("m_state", 32'(exec_state),  32'(m_state));
      chk("m_count", step_count,       m_count);
      chk("m_hit",   32'(bp_hit),      32'(m_state == 2));
      step_pulse = 1'b0; run_pulse = 1'b0; halt_pulse = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step_pulse = 1'b0; run_pulse = 1'b0; halt_pulse = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_en",    32'(cpu_step_en), 32'd0);
      chk("rst_state", 32'(exec_state),  32'd0);
      chk("rst_count", step_count,       32'd0);
      chk("rst_hit",   32'(bp_hit),      32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   typedef struct {
      bit s, r, h;
      bit          en;
      logic [1:0]  st;
      logic [31:0] cnt;
      bit          hit;
   } vec_t;

   vec_t   vecs[15];
   longint base;
   int     en_edges[$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      bp_enable = 1'b0; bp_addr = '0; debug_pc = '0;
      step_pulse = 1'b0; run_pulse = 1'b0; halt_pulse = 1'b0;
      model_reset();
      #12;
      do_reset();

      // ---- table-driven: stepping and pulse priority from HALTED ----
      vecs[0]  = '{0,0,0, 0,2'b00,32'd0,0};
      vecs[1]  = '{1,0,0, 1,2'b00,32'd1,0};
      vecs[2]  = '{0,0,0, 0,2'b00,32'd1,0};
      vecs[3]  = '{1,1,1, 0,2'b00,32'd1,0};
      vecs[4]  = '{0,0,0, 0,2'b00,32'd1,0};
      vecs[5]  = '{1,1,0, 0,2'b01,32'd1,0};
      vecs[6]  = '{0,0,0, 0,2'b01,32'd1,0};
      vecs[7]  = '{0,0,1, 0,2'b00,32'd1,0};
      vecs[8]  = '{0,0,0, 0,2'b00,32'd1,0};
      vecs[9]  = '{1,0,0, 1,2'b00,32'd2,0};
      vecs[10] = '{1,0,0, 0,2'b00,32'd2,0};
      vecs[11] = '{1,0,0, 1,2'b00,32'd3,0};
      vecs[12] = '{0,0,0, 0,2'b00,32'd3,0};
      vecs[13] = '{0,0,1, 0,2'b00,32'd3,0};
      vecs[14] = '{1,0,1, 0,2'b00,32'd3,0};
      for (int i = 0; i < 15; i++) begin
         tick(vecs[i].s, vecs[i].r, vecs[i].h);
         chk($sformatf("vec%0d_en", i),    32'(cpu_step_en), 32'(vecs[i].en));
         chk($sformatf("vec%0d_state", i), 32'(exec_state),  32'(vecs[i].st));
         chk($sformatf("vec%0d_count", i), step_count,       vecs[i].cnt);
         chk($sformatf("vec%0d_hit", i),   32'(bp_hit),      32'(vecs[i].hit));
      end

      // ---- free run: ticks DIV edges apart, stop on run_pulse ----
      do_reset();
      tick(0, 1, 0);
      en_edges.delete();
      for (int k = 1; k < 35; k++) begin
         tick(0, 0, 0);
         if (cpu_step_en) en_edges.push_back(k);
         if (k == 31) chk("run_count31", step_count, 32'd3);
      end
      chk("run_n_en", 32'(en_edges.size()), 32'd3);
      if (en_edges.size() == 3) begin
         chk("run_en0", 32'(en_edges[0]), 32'd10);
         chk("run_en1", 32'(en_edges[1]), 32'd20);
         chk("run_en2", 32'(en_edges[2]), 32'd30);
      end
      tick(0, 1, 0);
      chk("run_stop_state", 32'(exec_state), 32'd0);
      repeat (25) tick(0, 0, 0);
      chk("run_stop_count", step_count, 32'd3);

      // ---- breakpoint at 0xC, idle in BREAK, resume without re-break ----
      do_reset();
      bp_enable = 1'b1; bp_addr = 32'h0000_000C;
      tick(0, 1, 0);
      repeat (32) tick(0, 0, 0);
      chk("bp_state", 32'(exec_state), 32'd2);
      chk("bp_hit",   32'(bp_hit),     32'd1);
      chk("bp_count", step_count,      32'd3);
      repeat (100) tick(0, 0, 0);
      chk("bp_idle_count", step_count,  32'd3);
      chk("bp_idle_state", 32'(exec_state), 32'd2);
      tick(0, 1, 0);
      chk("resume_hit", 32'(bp_hit), 32'd0);
      repeat (9) tick(0, 0, 0);
      chk("resume_early", 32'(cpu_step_en), 32'd0);
      tick(0, 0, 0);
      chk("resume_tick", 32'(cpu_step_en), 32'd1);
      repeat (15) tick(0, 0, 0);
      chk("resume_nobreak", 32'(exec_state), 32'd1);
      bp_addr = 32'h0000_0018;
      repeat (30) tick(0, 0, 0);
      chk("bp2_state", 32'(exec_state), 32'd2);
      tick(1, 0, 0);
      chk("brk_step_en",    32'(cpu_step_en), 32'd1);
      chk("brk_step_state", 32'(exec_state),  32'd2);
      chk("brk_step_hit",   32'(bp_hit),      32'd1);
      tick(0, 0, 0);
      tick(0, 0, 1);
      chk("brk_halt_state", 32'(exec_state), 32'd0);
      chk("brk_halt_hit",   32'(bp_hit),     32'd0);
      bp_enable = 1'b0;

      // ---- asynchronous reset with the divider at 7 ----
      do_reset();
      tick(0, 1, 0);
      repeat (DIV + 7) tick(0, 0, 0);
      chk("pre_rst_count", step_count, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_en",    32'(cpu_step_en), 32'd0);
      chk("arst_state", 32'(exec_state),  32'd0);
      chk("arst_count", step_count,       32'd0);
      chk("arst_hit",   32'(bp_hit),      32'd0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      repeat (30) tick(0, 0, 0);
      chk("post_rst_count", step_count, 32'd0);

      // ---- step_count wrap ----
      do_reset();
      @(negedge clk);
      dut.count_q = 32'hFFFF_FFFF;
      m_count     = 32'hFFFF_FFFF;
      tick(0, 0, 0);
      chk("wrap_pre", step_count, 32'hFFFF_FFFF);
      tick(1, 0, 0);
      chk("wrap_count", step_count, 32'd0);
      chk("wrap_en", 32'(cpu_step_en), 32'd1);

      // ---- randomized run against the model ----
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) bp_enable = ~bp_enable;
         if ($urandom_range(0, 19) == 0) bp_addr = m_pc + 32'(4 * $urandom_range(0, 3));
         if ($urandom_range(0, 799) == 0) do_reset();
         tick($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 3,
              $urandom_range(0, 99) < 2);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
